// File: rtl/sgmii_an_rx.sv
// SGMII auto-negotiation receive side: parses /C/ and /I/ ordered sets from decoded code groups
// and tracks ability match, acknowledge match and negotiation completion.
module sgmii_an_rx #(
  parameter int unsigned MATCH_CNT = 3,
  parameter int unsigned IDLE_CNT  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_is_k,
  input  logic        an_restart,
  output logic [15:0] partner_config,
  output logic        ability_match,
  output logic        ack_match,
  output logic        an_complete,
  output logic        link_up,
  output logic        full_duplex,
  output logic [1:0]  speed,
  output logic        set_error
);

  localparam int unsigned MW = $clog2(MATCH_CNT + 1);
  localparam int unsigned IW = $clog2(IDLE_CNT + 1);
  localparam logic [MW-1:0] MatchMax = MW'(MATCH_CNT);
  localparam logic [IW-1:0] IdleMax  = IW'(IDLE_CNT);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  // Bit 14 is the acknowledge bit and does not take part in word comparison.
  localparam logic [15:0] CmpMask = 16'hBFFF;

  typedef enum logic [1:0] {StHunt, StComma, StCLo, StCHi} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lo_q;
  logic [15:0]     prev_q;
  logic [15:0]     partner_q, partner_d;
  logic [MW-1:0]   match_cnt_q, match_cnt_d;
  logic [MW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            complete_q, complete_d;
  logic            set_error_q;

  logic            word_done, idle_seen, frame_err, lo_en;
  logic [15:0]     word;

  assign word = {rx_data, lo_q};

  // State register; an_restart acts exactly like reset and wins over a completing word.
  always_ff @(posedge clock) begin
    if (reset || an_restart) begin
      state_q     <= StHunt;
      lo_q        <= '0;
      prev_q      <= '0;
      partner_q   <= '0;
      match_cnt_q <= '0;
      ack_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      complete_q  <= 1'b0;
      set_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      partner_q   <= partner_d;
      match_cnt_q <= match_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      complete_q  <= complete_d;
      set_error_q <= frame_err;
      if (lo_en) lo_q <= rx_data;
      if (word_done) prev_q <= word;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        StHunt:  if (rx_is_k && rx_data == K28_5) state_d = StComma;
        StComma: begin
          if (rx_is_k) state_d = (rx_data == K28_5) ? StComma : StHunt;
          else if (rx_data == D21_5 || rx_data == D2_2) state_d = StCLo;
          else state_d = StHunt;
        end
        StCLo:   state_d = rx_is_k ? StHunt : StCHi;
        StCHi:   state_d = StHunt;
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    word_done = 1'b0;
    idle_seen = 1'b0;
    frame_err = 1'b0;
    lo_en     = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StHunt: ;
        StComma: begin
          if (rx_is_k) frame_err = (rx_data != K28_5);
          else if (rx_data == D5_6 || rx_data == D16_2) idle_seen = 1'b1;
          else if (rx_data != D21_5 && rx_data != D2_2) frame_err = 1'b1;
        end
        StCLo: begin
          frame_err = rx_is_k;
          lo_en     = !rx_is_k;
        end
        StCHi: begin
          frame_err = rx_is_k;
          word_done = !rx_is_k;
        end
        default: ;
      endcase
    end
  end

  // Match / acknowledge / idle bookkeeping for completed words and /I/ sets.
  always_comb begin
    match_cnt_d = match_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    complete_d  = complete_q;
    partner_d   = partner_q;
    if (word_done) begin
      idle_cnt_d = '0;
      if (word == 16'h0000) begin
        match_cnt_d = '0;
        ack_cnt_d   = '0;
        complete_d  = 1'b0;
      end else if (match_cnt_q != '0 && (word & CmpMask) == (prev_q & CmpMask)) begin
        if (match_cnt_q != MatchMax) match_cnt_d = match_cnt_q + MW'(1);
        if (!word[14]) ack_cnt_d = '0;
        else if (ack_cnt_q != MatchMax) ack_cnt_d = ack_cnt_q + MW'(1);
      end else begin
        // First word of a new run; an acknowledge run needs a preceding equal word.
        match_cnt_d = MW'(1);
        ack_cnt_d   = '0;
        complete_d  = 1'b0;
      end
      if (match_cnt_d == MatchMax) partner_d = word;
    end else if (idle_seen && ack_cnt_q == MatchMax) begin
      if (idle_cnt_q != IdleMax) idle_cnt_d = idle_cnt_q + IW'(1);
      if (idle_cnt_d == IdleMax) complete_d = 1'b1;
    end
  end

  assign partner_config = partner_q;
  assign ability_match  = (match_cnt_q == MatchMax);
  assign ack_match      = (ack_cnt_q == MatchMax);
  assign an_complete    = complete_q;
  assign link_up        = complete_q & partner_q[15];
  assign full_duplex    = complete_q & partner_q[12];
  assign speed          = complete_q ? partner_q[11:10] : 2'b00;
  assign set_error      = set_error_q;

endmodule

// File: doc/sgmii_an_rx.md
SGMII_AN_RX -- requirements
Module: sgmii_an_rx

Interface
REQ-001 SHALL have parameter MATCH_CNT, default 3: consecutive identical config words required for ability/ack match (range 2..7).
REQ-002 SHALL have parameter IDLE_CNT, default 4: consecutive /I/ ordered sets after ack match required to declare completion (range 1..15).
REQ-003 SHALL have port clock  in  1  single 125 MHz decoded-code-group clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port rx_valid  in  1  one decoded code group presented this cycle.
REQ-006 SHALL have port rx_data  in  8  decoded octet.
REQ-007 SHALL have port rx_is_k  in  1  octet is a K code.
REQ-008 SHALL have port an_restart  in  1  level; while high, returns to HUNT and clears match state.
REQ-009 SHALL have port partner_config  out  16  last ability-matched config word.
REQ-010 SHALL have port ability_match  out  1  MATCH_CNT identical words (bit 14 ignored) received.
REQ-011 SHALL have port ack_match  out  1  MATCH_CNT consecutive ability-matching words with bit 14 set.
REQ-012 SHALL have port an_complete  out  1  ack_match followed by IDLE_CNT consecutive /I/.
REQ-013 SHALL have port link_up / full_duplex / speed  out  1/1/2  decoded from partner_config bits 15/12/11:10, valid only while an_complete.
REQ-014 SHALL have port set_error  out  1  one-cycle pulse on malformed ordered set.

Function
REQ-015 SHALL parse ordered sets with FSM HUNT -> COMMA -> (C_LO -> C_HI) or IDLE_D -> COMMA/HUNT; state advances only on rx_valid cycles.
REQ-016 HUNT: K28.5 (rx_is_k, 0xBC) -> COMMA; anything else stays in HUNT, no error.
REQ-017 COMMA: data D21.5 (0xB5) or D2.2 (0x42) -> C_LO; D5.6 (0xC5) or D16.2 (0x50) -> counts one /I/, back to HUNT; K28.5 stays in COMMA; any other -> HUNT with set_error pulse.
REQ-018 C_LO captures low octet; C_HI captures high octet and completes one config word; any K code in C_LO/C_HI -> HUNT, set_error pulse, word discarded.
REQ-019 Completed word compared (bits 15,13:0) with previous word; equal -> match counter +1, saturating at MATCH_CNT; differ -> counter = 1, ability_match, ack_match, an_complete cleared.
REQ-020 ability_match SHALL assert the cycle after the C_HI octet that brings counter to MATCH_CNT; partner_config updated same cycle.
REQ-021 Separate ack counter SHALL increment on words that match and have bit 14 set, reset to 0 on bit 14 clear or mismatch; ack_match asserts when it reaches MATCH_CNT.
REQ-022 Idle counter SHALL increment per /I/ only while ack_match, saturating at IDLE_CNT; any completed config word resets it to 0.
REQ-023 an_complete SHALL assert the cycle after idle counter reaches IDLE_CNT; remains high until reset, an_restart, or a completed config word differing from partner_config.
REQ-024 Config word of all zeros (partner restart) SHALL clear ability_match, ack_match, an_complete and counters immediately.
REQ-025 rx_valid low cycles SHALL hold all state; they do not break consecutiveness.
REQ-026 an_restart and a completing word in the same cycle: an_restart wins, word discarded.
REQ-027 link_up, full_duplex, speed SHALL be 0 whenever an_complete is 0.

Reset
REQ-028 On reset (and an_restart): FSM = HUNT, all counters 0, partner_config = 16'h0000, every output 0, set_error not pulsed.
REQ-029 Reset mid-ordered-set SHALL discard the partial word; first word after reset counts as 1.

Verification
REQ-030 Three /C1/,/C2/ alternating sets with word 16'h9801 -> ability_match=1, partner_config=16'h9801, ack_match=0 after third.
REQ-031 Then three words 16'hD801 then four /I2/ (BC,50) -> ack_match after third word, an_complete after fourth idle; link_up=1, full_duplex=1, speed=2'b10.
REQ-032 Two 16'h9801 words then 16'h9401 -> counter restarts at 1, ability_match stays 0; two more 16'h9401 -> ability_match=1.
REQ-033 BC then K-code in C_LO position -> set_error one-cycle pulse, FSM HUNT, match counter unchanged.
REQ-034 While an_complete=1, three words 16'h0000 -> an_complete, link_up drop the cycle after first zero word.
REQ-035 rx_valid toggled 50% between every octet of REQ-031 sequence -> identical final outputs; an_restart pulse afterwards -> all outputs 0 next cycle.
